// File: rtl/alu_sequencer.sv
// Sequencer that drives an external combinational 8-bit ALU from a 4-entry register file.
// Instructions and responses each use a valid/ready handshake with a one-cycle IDLE gap between them.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  // Handshake rule for both channels: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload until then and the sequencer samples it only on that edge.
  input  logic        Instr_Valid,
  output logic        Instr_Ready,
  input  logic [15:0] Instr,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [3:0]  ALU_Sel,
  input  logic [7:0]  ALU_Out,
  input  logic        CarryOut,
  input  logic        ZeroFlag,
  input  logic        OverflowFlag,
  input  logic        SignFlag,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [7:0]  Resp_Data,
  output logic [3:0]  Resp_Flags,
  output logic        Resp_Err,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] SETTLE = SETTLE_CYCLES[3:0];

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_LDI = 2'b01;
  localparam logic [1:0] MODE_RD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  regs [4];
  logic [3:0]  flags;
  logic [3:0]  settle_cnt;
  logic [1:0]  rd_q;

  logic [1:0]  mode;
  logic [3:0]  sel;
  logic [1:0]  rd;
  logic [1:0]  ra;
  logic [1:0]  rb;
  logic [7:0]  imm;
  logic        accept;
  logic        capture;

  assign mode = Instr[15:14];
  assign sel  = Instr[13:10];
  assign rd   = Instr[9:8];
  assign ra   = Instr[7:6];
  assign rb   = Instr[5:4];
  assign imm  = Instr[7:0];

  assign accept  = Instr_Valid && (state == ST_IDLE);
  assign capture = (state == ST_EXEC) && (settle_cnt == SETTLE);

  assign Instr_Ready = (state == ST_IDLE);
  assign Resp_Valid  = (state == ST_RESP);
  assign Resp_Flags  = flags;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (mode == MODE_ALU) ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        if (capture) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Return to IDLE rather than accepting here, so a new instruction never overlaps a response.
        if (Resp_Ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      flags      <= '0;
      settle_cnt <= '0;
      rd_q       <= '0;
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_Sel    <= '0;
      Resp_Data  <= '0;
      Resp_Err   <= 1'b0;
    end else if (accept) begin
      case (mode)
        MODE_ALU: begin
          // Operands are read now and the result written at capture, so Rd may alias Ra/Rb.
          ALU_A      <= regs[ra];
          ALU_B      <= regs[rb];
          ALU_Sel    <= sel;
          rd_q       <= rd;
          settle_cnt <= 4'd1;
        end
        MODE_LDI: begin
          regs[rd]  <= imm;
          Resp_Data <= imm;
          Resp_Err  <= 1'b0;
        end
        MODE_RD: begin
          Resp_Data <= regs[ra];
          Resp_Err  <= 1'b0;
        end
        default: begin
          Resp_Data <= '0;
          Resp_Err  <= 1'b1;
        end
      endcase
    end else if (state == ST_EXEC) begin
      if (capture) begin
        regs[rd_q] <= ALU_Out;
        flags      <= {CarryOut, ZeroFlag, OverflowFlag, SignFlag};
        Resp_Data  <= ALU_Out;
        Resp_Err   <= 1'b0;
      end else begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  a_resp_stable: assert property (
    @(posedge clk) disable iff (rst)
    (Resp_Valid && !Resp_Ready) |=>
      (Resp_Valid && $stable(Resp_Data) && $stable(Resp_Err) && $stable(Resp_Flags))
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (settle 1 and 3), each wired to an 8-bit ALU model,
// with a response scoreboard fed from a register/flag model of the sequencer.
module tb_alu_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        instr_valid;
  logic [1:0][15:0]  instr;
  logic [1:0]        resp_ready;
  logic [1:0]        instr_ready;
  logic [1:0][7:0]   alu_a;
  logic [1:0][7:0]   alu_b;
  logic [1:0][3:0]   alu_sel;
  logic [1:0][11:0]  alu_res;
  logic [1:0]        resp_valid;
  logic [1:0][7:0]   resp_data;
  logic [1:0][3:0]   resp_flags;
  logic [1:0]        resp_err;
  logic [1:0][1:0]   dbg_state;

  // Returns {C,Z,O,S,result}. 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor,
  // 1100 shift left (C = bit out), 1101 shift right (C = bit out), others pass A.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
    logic [8:0] t;
    logic [7:0] r;
    logic c, o;
    t = '0; r = a; c = 1'b0; o = 1'b0;
    case (sel)
      4'b0000: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8];
                     o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'b0001: begin t = {1'b0, a} + {1'b0, ~b} + 9'd1; r = t[7:0]; c = t[8];
                     o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b1100: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'b1101: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = a;
    endcase
    return {c, (r == 8'h00), o, r[7], r};
  endfunction

  assign alu_res[0] = alu_model(alu_a[0], alu_b[0], alu_sel[0]);
  assign alu_res[1] = alu_model(alu_a[1], alu_b[1], alu_sel[1]);

  alu_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .Instr_Valid(instr_valid[0]), .Instr_Ready(instr_ready[0]), .Instr(instr[0]),
    .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_Sel(alu_sel[0]), .ALU_Out(alu_res[0][7:0]),
    .CarryOut(alu_res[0][11]), .ZeroFlag(alu_res[0][10]),
    .OverflowFlag(alu_res[0][9]), .SignFlag(alu_res[0][8]),
    .Resp_Valid(resp_valid[0]), .Resp_Ready(resp_ready[0]), .Resp_Data(resp_data[0]),
    .Resp_Flags(resp_flags[0]), .Resp_Err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  alu_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .Instr_Valid(instr_valid[1]), .Instr_Ready(instr_ready[1]), .Instr(instr[1]),
    .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_Sel(alu_sel[1]), .ALU_Out(alu_res[1][7:0]),
    .CarryOut(alu_res[1][11]), .ZeroFlag(alu_res[1][10]),
    .OverflowFlag(alu_res[1][9]), .SignFlag(alu_res[1][8]),
    .Resp_Valid(resp_valid[1]), .Resp_Ready(resp_ready[1]), .Resp_Data(resp_data[1]),
    .Resp_Flags(resp_flags[1]), .Resp_Err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard / model ----------------
  logic [12:0] exp_q[$];          // {err, flags[3:0], data[7:0]}
  logic [7:0]  regs_m [2][4];
  logic [3:0]  flags_m [2];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  last_data;
  logic [3:0]  last_flags;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] op_alu(input logic [3:0] sel, input logic [1:0] rd,
                                         input logic [1:0] ra, input logic [1:0] rb);
    return {2'b00, sel, rd, ra, rb, 4'b0000};
  endfunction

  function automatic logic [15:0] op_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, 4'b0000, rd, imm};
  endfunction

  function automatic logic [15:0] op_rd(input logic [1:0] ra);
    return {2'b10, 4'b0000, 2'b00, ra, 6'b000000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      flags_m[u] = '0;
      for (int r = 0; r < 4; r++) regs_m[u][r] = '0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = '0;
    resp_ready = '0;
    instr = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input int u, input logic [15:0] ins, input int stall);
    logic [1:0]  mode, rd, ra, rb;
    logic [3:0]  sel;
    logic [11:0] res;
    logic [7:0]  ea, eb;
    logic [12:0] e;
    int          n, lat, exp_lat;
    mode = ins[15:14]; sel = ins[13:10]; rd = ins[9:8]; ra = ins[7:6]; rb = ins[5:4];
    instr[u] = ins;
    instr_valid[u] = 1'b1;
    n = 0;
    while (!instr_ready[u] && n < 50) begin
      tick();
      n++;
    end
    if (!instr_ready[u]) begin
      check("instr_ready_timeout", 32'(instr_ready[u]), 1);
      instr_valid[u] = 1'b0;
      return;
    end
    ea = regs_m[u][ra];
    eb = regs_m[u][rb];
    exp_lat = 0;
    case (mode)
      2'b00: begin
        res = alu_model(ea, eb, sel);
        regs_m[u][rd] = res[7:0];
        flags_m[u] = res[11:8];
        exp_q.push_back({1'b0, flags_m[u], res[7:0]});
        exp_lat = settle_of(u);
      end
      2'b01: begin
        regs_m[u][rd] = ins[7:0];
        exp_q.push_back({1'b0, flags_m[u], ins[7:0]});
      end
      2'b10: exp_q.push_back({1'b0, flags_m[u], ea});
      default: exp_q.push_back({1'b1, flags_m[u], 8'h00});
    endcase
    tick();
    instr_valid[u] = 1'b0;
    instr[u] = 16'($urandom);
    lat = 0;
    while (!resp_valid[u] && lat < 40) begin
      if (mode == 2'b00) begin
        check("exec_alu_a", 32'(alu_a[u]), 32'(ea));
        check("exec_alu_b", 32'(alu_b[u]), 32'(eb));
        check("exec_alu_sel", 32'(alu_sel[u]), 32'(sel));
      end
      tick();
      lat++;
    end
    check("latency", lat, exp_lat);
    if (!resp_valid[u]) begin
      e = exp_q.pop_front();
      return;
    end
    if (mode == 2'b00) check("resp_alu_a_hold", 32'(alu_a[u]), 32'(ea));
    e = exp_q[0];
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 32'(resp_valid[u]), 1);
      check("stall_instr_ready", 32'(instr_ready[u]), 0);
      check("stall_data", 32'(resp_data[u]), 32'(e[7:0]));
      check("stall_flags", 32'(resp_flags[u]), 32'(e[11:8]));
      tick();
    end
    e = exp_q.pop_front();
    check("resp_data", 32'(resp_data[u]), 32'(e[7:0]));
    check("resp_flags", 32'(resp_flags[u]), 32'(e[11:8]));
    check("resp_err", 32'(resp_err[u]), 32'(e[12]));
    last_data = resp_data[u];
    last_flags = resp_flags[u];
    last_err = resp_err[u];
    resp_ready[u] = 1'b1;
    tick();
    resp_ready[u] = 1'b0;
    check("post_hs_valid", 32'(resp_valid[u]), 0);
    check("post_hs_instr_ready", 32'(instr_ready[u]), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ins;
    do_reset();
    for (int u = 0; u < 2; u++) begin
      check("rst_instr_ready", 32'(instr_ready[u]), 1);
      check("rst_resp_valid", 32'(resp_valid[u]), 0);
      check("rst_resp_flags", 32'(resp_flags[u]), 0);
    end

    // Signed overflow on add.
    do_txn(0, op_ldi(2'd0, 8'h7F), 0);
    do_txn(0, op_ldi(2'd1, 8'h01), 0);
    do_txn(0, op_alu(4'b0000, 2'd2, 2'd0, 2'd1), 0);
    check("add_data", 32'(last_data), 32'h80);
    check("add_flags", 32'(last_flags), 32'b0011);
    do_txn(0, op_rd(2'd2), 0);
    check("add_r2", 32'(last_data), 32'h80);

    // Equal subtract gives zero with carry; read-reg leaves flags alone.
    do_txn(0, op_ldi(2'd0, 8'h05), 0);
    do_txn(0, op_ldi(2'd1, 8'h05), 0);
    do_txn(0, op_alu(4'b0001, 2'd3, 2'd0, 2'd1), 0);
    check("sub_data", 32'(last_data), 32'h00);
    check("sub_flags", 32'(last_flags), 32'b1100);
    do_txn(0, op_rd(2'd3), 0);
    check("sub_r3", 32'(last_data), 32'h00);
    check("sub_read_flags", 32'(last_flags), 32'b1100);

    // Consumer back-pressure for five cycles.
    do_txn(0, op_alu(4'b0100, 2'd0, 2'd2, 2'd3), 5);
    check("stall_result", 32'(last_data), 32'h80);

    // Longer settle: shift left of 0x81 on the 3-cycle instance.
    do_txn(1, op_ldi(2'd0, 8'h81), 0);
    do_txn(1, op_alu(4'b1100, 2'd2, 2'd0, 2'd0), 2);
    check("shl_data", 32'(last_data), 32'h02);
    check("shl_flags", 32'(last_flags), 32'b1000);

    // Reset while an ALU op is in EXEC.
    do_txn(0, op_ldi(2'd1, 8'h5A), 0);
    instr[0] = op_alu(4'b0100, 2'd1, 2'd0, 2'd1);
    instr_valid[0] = 1'b1;
    tick();
    instr_valid[0] = 1'b0;
    check("rst_exec_state", 32'(dbg_state[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_exec_instr_ready", 32'(instr_ready[0]), 1);
    check("rst_exec_resp_valid", 32'(resp_valid[0]), 0);
    check("rst_exec_flags", 32'(resp_flags[0]), 0);
    for (int i = 0; i < 4; i++) begin
      check("rst_exec_no_resp", 32'(resp_valid[0]), 0);
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      do_txn(0, op_rd(2'(r)), 0);
      check("rst_exec_reg_zero", 32'(last_data), 0);
    end

    // Reserved mode after an ALU op, then a load clears the error.
    do_txn(0, op_ldi(2'd0, 8'hF0), 0);
    do_txn(0, op_ldi(2'd1, 8'h20), 0);
    do_txn(0, op_alu(4'b0000, 2'd2, 2'd0, 2'd1), 0);
    do_txn(0, {2'b11, 14'h2A5C}, 1);
    check("rsv_err", 32'(last_err), 1);
    check("rsv_data", 32'(last_data), 0);
    check("rsv_flags", 32'(last_flags), 32'b1000);
    do_txn(0, op_rd(2'd2), 0);
    check("rsv_r2_kept", 32'(last_data), 32'h10);
    do_txn(0, op_ldi(2'd3, 8'h44), 0);
    check("ldi_after_rsv_err", 32'(last_err), 0);

    // Random mixed traffic on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 40; k++) begin
        ins = 16'($urandom);
        if ($urandom_range(0, 2) == 0) ins[15:14] = 2'b01;
        do_txn(u, ins, $urandom_range(0, 2));
      end
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, 1, cycles the ALU operands are held before result capture (legal 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Instr_Valid  in  1  instruction offered.
REQ-005 Instr_Ready  out  1  sequencer can accept an instruction.
REQ-006 Instr  in  16  [15:14] Mode (00 ALU op, 01 load-imm, 10 read-reg, 11 reserved); [13:10] Sel; [9:8] Rd; [7:6] Ra; [5:4] Rb; [7:0] Imm (load-imm only).
REQ-007 ALU_A  out  8  operand A to the external ALU.
REQ-008 ALU_B  out  8  operand B to the external ALU.
REQ-009 ALU_Sel  out  4  operation select to the external ALU, passed unmodified from Instr Sel.
REQ-010 ALU_Out  in  8  ALU result.
REQ-011 CarryOut, ZeroFlag, OverflowFlag, SignFlag  in  1 each  ALU flags.
REQ-012 Resp_Valid  out  1  response available.
REQ-013 Resp_Ready  in  1  consumer accepts response.
REQ-014 Resp_Data  out  8  response data.
REQ-015 Resp_Flags  out  4  flag register {C,Z,O,S}.
REQ-016 Resp_Err  out  1  reserved Mode was received.

Function
REQ-017 State: four 8-bit registers R0..R3, 4-bit flag register, FSM {IDLE, EXEC, RESP}, 4-bit settle counter.
REQ-018 Instr_Ready SHALL be 1 exactly when FSM is IDLE; Resp_Valid SHALL be 1 exactly when FSM is RESP.
REQ-019 Accept: Instr_Valid && Instr_Ready at a rising edge; Instr SHALL be sampled only at that edge.
REQ-020 ALU op accept: ALU_A<=R[Ra], ALU_B<=R[Rb], ALU_Sel<=Sel, counter<=1, FSM->EXEC.
REQ-021 EXEC: ALU_A/ALU_B/ALU_Sel registered and stable; counter increments each edge while counter<SETTLE_CYCLES.
REQ-022 EXEC edge with counter==SETTLE_CYCLES: R[Rd]<=ALU_Out, flags<={CarryOut,ZeroFlag,OverflowFlag,SignFlag}, Resp_Data<=ALU_Out, Resp_Err<=0, FSM->RESP.
REQ-023 ALU-op latency: Resp_Valid rises exactly SETTLE_CYCLES edges after the accept edge.
REQ-024 Load-imm accept: R[Rd]<=Imm, Resp_Data<=Imm, Resp_Err<=0, flags unchanged, FSM->RESP directly (1 edge latency).
REQ-025 Read-reg accept: Resp_Data<=R[Ra], Resp_Err<=0, no register or flag change, FSM->RESP directly.
REQ-026 Reserved accept: Resp_Data<=0, Resp_Err<=1, no register or flag change, FSM->RESP directly.
REQ-027 RESP: Resp_Data, Resp_Flags, Resp_Err held stable until Resp_Valid && Resp_Ready edge, then FSM->IDLE.
REQ-028 No response pass-through: new instruction accepted no earlier than the edge after response handshake (one IDLE cycle minimum).
REQ-029 Rd equal to Ra or Rb: operands read at accept edge, write at capture edge; no hazard.
REQ-030 Resp_Flags SHALL always show the flag register (reflects last ALU op only).
REQ-031 ALU_A/ALU_B/ALU_Sel SHALL hold their last values outside EXEC.
REQ-032 SETTLE_CYCLES outside 1..15 is illegal; behaviour undefined.

Reset
REQ-033 rst high at an edge: FSM<=IDLE, R0..R3<=0, flags<=0, counter<=0, ALU_A/ALU_B<=0, ALU_Sel<=0, Resp_Data<=0, Resp_Err<=0; overrides any handshake that edge.
REQ-034 After reset: Instr_Ready=1, Resp_Valid=0, Resp_Flags=0; reset in EXEC or RESP aborts with no register write and no response.

Verification (bench instantiates the 8-bit ALU model on the ALU_* side, SETTLE_CYCLES=1 unless stated)
REQ-035 Load R0=0x7F, R1=0x01; ALU op Sel=0000 Rd=2 Ra=0 Rb=1 -> Resp_Data=0x80, Resp_Flags={0,0,1,1}, R2=0x80, Resp_Valid 1 edge after accept.
REQ-036 Load R0=0x05, R1=0x05; Sel=0001 Rd=3 -> Resp_Data=0x00, Z=1, C=1, O=0, S=0; read-reg Ra=3 -> 0x00 with flags unchanged.
REQ-037 Resp_Ready low 5 cycles in RESP -> Resp_Valid/Resp_Data/Resp_Flags stable, Instr_Ready=0 throughout; IDLE one edge after Resp_Ready high.
REQ-038 rst pulsed during EXEC of Sel=0100 Rd=1 -> next cycle Instr_Ready=1, Resp_Valid=0, all registers and flags 0, no response.
REQ-039 Mode=11 after an ALU op -> Resp_Err=1, Resp_Data=0x00, registers and Resp_Flags unchanged; next load-imm returns Resp_Err=0.
REQ-040 SETTLE_CYCLES=3, Sel=1100 Ra=0 with R0=0x81 -> ALU_* stable 3 cycles, Resp_Valid 3 edges after accept, Resp_Data=0x02, C=1.
